// File: rtl/pio_pkg.sv
// pio_pkg: register map and edge-mode encodings shared by the PIO edge-capture slave.
`default_nettype none

package pio_pkg;

  typedef enum logic [1:0] {
    PIO_ADDR_DATA     = 2'd0,
    PIO_ADDR_RESERVED = 2'd1,
    PIO_ADDR_IRQMASK  = 2'd2,
    PIO_ADDR_EDGECAP  = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

`default_nettype wire

// File: rtl/pio_sync_edge.sv
// pio_sync_edge: multi-flop input synchroniser plus a one-cycle-delayed copy for edge detection.
`default_nettype none

module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE_MODE == EDGE_FALLING) begin : g_falling
      assign edge_o = ~sync_o & prev_q;
    end else if (EDGE_MODE == EDGE_ANY) begin : g_any
      assign edge_o = sync_o ^ prev_q;
    end else begin : g_rising
      assign edge_o = sync_o & ~prev_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/pio_in_edge_capture.sv
// pio_in_edge_capture: input PIO slave with sticky per-bit edge capture, interrupt mask and level IRQ.
`default_nettype none

module pio_in_edge_capture
  import pio_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter int               SYNC_STAGES    = 2,
  parameter int               EDGE_MODE      = EDGE_RISING,
  parameter logic [WIDTH-1:0] IRQ_MASK_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] edge_w;

  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] clear_w;
  logic             wr_w;
  logic             unused_wd;

  pio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_MODE  (EDGE_MODE)
  ) u_sync_edge (
    .clk    (clk),
    .reset  (reset),
    .async_i(in_port),
    .sync_o (sync_w),
    .edge_o (edge_w)
  );

  assign wr_w      = chipselect & ~write_n;
  assign unused_wd = &{1'b0, writedata};

  always_comb begin
    irqmask_d  = irqmask_q;
    clear_w    = '0;
    readdata_d = '0;

    if (wr_w && (pio_addr_e'(address) == PIO_ADDR_IRQMASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (wr_w && (pio_addr_e'(address) == PIO_ADDR_EDGECAP)) begin
      clear_w = writedata[WIDTH-1:0];
    end

    // A new edge overrides a same-cycle clear of the same bit.
    edgecap_d = (edgecap_q & ~clear_w) | edge_w;

    // Read mux is evaluated every cycle; chipselect does not gate it.
    case (pio_addr_e'(address))
      PIO_ADDR_DATA:    readdata_d[WIDTH-1:0] = sync_w;
      PIO_ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      PIO_ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:          readdata_d = '0;
    endcase

    irq_d = |(edgecap_q & irqmask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irqmask_q  <= IRQ_MASK_RESET;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_pio_in_edge_capture.sv
// tb_pio_in_edge_capture: directed and random checks of three edge-mode instances against a history-based model.
`default_nettype none
`timescale 1ns/1ps

module tb_pio_in_edge_capture;
  import pio_pkg::*;

  localparam int         W    = 8;
  localparam int         S    = 2;
  localparam logic [7:0] MRST = 8'h5A;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [W-1:0] in_port = '0;

  logic [2:0][31:0] rd;
  logic [2:0]       irqv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // One instance per edge mode: 0 rising, 1 falling, 2 any.
  generate
    for (genvar m = 0; m < 3; m++) begin : g_dut
      pio_in_edge_capture #(
        .WIDTH         (W),
        .SYNC_STAGES   (S),
        .EDGE_MODE     (m),
        .IRQ_MASK_RESET(MRST)
      ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (rd[m]),
        .in_port   (in_port),
        .irq       (irqv[m])
      );
    end
  endgenerate

  // Reference model: the synchronised level is the input sampled S edges ago,
  // unless that sample predates the most recent reset.
  logic [W-1:0] hist [0:8191];
  int           n        = 0;
  int           last_rst = 0;
  bit           valid    = 1'b0;
  logic [W-1:0] ec_m [3];
  logic [W-1:0] mask_m;
  logic         irq_m [3];
  logic [W-1:0] rd_m [3];

  function automatic logic [W-1:0] sync_after(int k);
    int j = k - S + 1;
    if (j <= last_rst) return '0;
    return hist[j];
  endfunction

  function automatic logic [W-1:0] prev_after(int k);
    if (k <= last_rst) return '0;
    return sync_after(k - 1);
  endfunction

  function automatic logic [W-1:0] edge_of(int mode, logic [W-1:0] s, logic [W-1:0] p);
    if (mode == 0) return s & ~p;
    if (mode == 1) return ~s & p;
    return s ^ p;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] s, p, clr;
    bit wr;
    n++;
    s   = sync_after(n - 1);
    p   = prev_after(n - 1);
    wr  = chipselect && !write_n;
    clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
    for (int m = 0; m < 3; m++) begin
      if (reset) begin
        ec_m[m]  = '0;
        irq_m[m] = 1'b0;
        rd_m[m]  = '0;
      end else begin
        irq_m[m] = |(ec_m[m] & mask_m);
        case (address)
          2'd0:    rd_m[m] = s;
          2'd2:    rd_m[m] = mask_m;
          2'd3:    rd_m[m] = ec_m[m];
          default: rd_m[m] = '0;
        endcase
        ec_m[m] = (ec_m[m] & ~clr) | edge_of(m, s, p);
      end
    end
    if (reset) mask_m = MRST;
    else if (wr && address == 2'd2) mask_m = writedata[W-1:0];
    if (reset) begin
      last_rst = n;
      valid    = 1'b1;
    end
    hist[n] = in_port;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (valid) begin
      for (int m = 0; m < 3; m++) begin
        check($sformatf("rd_mode%0d", m), rd[m], {24'h0, rd_m[m]});
        check($sformatf("irq_mode%0d", m), {31'h0, irqv[m]}, {31'h0, irq_m[m]});
      end
    end
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    // Reset and register readback
    reset = 1'b1;
    steps(3);
    reset = 1'b0;
    address = 2'd0; step(); check("t1_data", rd[0], 32'h0);
    address = 2'd1; step(); check("t1_rsvd", rd[0], 32'h0);
    address = 2'd2; step(); check("t1_mask", rd[0], {24'h0, MRST});
    address = 2'd3; step(); check("t1_ecap", rd[0], 32'h0);
    check("t1_irq", {31'h0, irqv[0]}, 32'h0);

    // Single-cycle pulse on bit 0, then write-1-to-clear
    bus_write(2'd2, 32'h01);
    address = 2'd3;
    in_port = 8'h01; step();
    in_port = 8'h00; step();
    step(); check("t2_irq_early", {31'h0, irqv[0]}, 32'h0);
    step(); check("t2_ecap", rd[0], 32'h1);
    check("t2_irq", {31'h0, irqv[0]}, 32'h1);
    bus_write(2'd3, 32'h01);
    address = 2'd3;
    step(); check("t2_ecap_clr", rd[0], 32'h0);
    check("t2_irq_clr", {31'h0, irqv[0]}, 32'h0);

    // Any-edge toggle on bit 3; DATA tracks the level
    address = 2'd0;
    in_port = 8'h08; step(); step();
    check("t3_data_lag", rd[2] & 32'h8, 32'h0);
    step(); check("t3_data_hi", rd[2] & 32'h8, 32'h8);
    in_port = 8'h00; steps(4);
    address = 2'd3; step();
    check("t3_sticky", rd[2] & 32'h8, 32'h8);

    // Rising edge on bit 2 coincides with its clear: edge wins
    in_port = 8'h04; step(); step();
    bus_write(2'd3, 32'h04);
    address = 2'd3; step();
    check("t4_edge_wins", rd[0] & 32'h4, 32'h4);

    // Masked capture, then unmask
    in_port = 8'h00; steps(4);
    bus_write(2'd2, 32'h00);
    bus_write(2'd3, 32'hFF);
    steps(2);
    in_port = 8'h80; steps(4);
    check("t5_masked_irq", {31'h0, irqv[0]}, 32'h0);
    bus_write(2'd2, 32'h80);
    address = 2'd3; step();
    check("t5_irq", {31'h0, irqv[0]}, 32'h1);
    check("t5_ecap", rd[0], 32'h80);

    // Reset with input held high: one rising edge after release
    in_port = 8'hFF; steps(4);
    address = 2'd2; reset = 1'b1; step();
    check("t6_rst_rd", rd[0], 32'h0);
    check("t6_rst_irq", {31'h0, irqv[0]}, 32'h0);
    reset = 1'b0; address = 2'd3;
    steps(3); check("t6_ecap_early", rd[0], 32'h0);
    step(); check("t6_ecap", rd[0], 32'hFF);
    check("t6_irq", {31'h0, irqv[0]}, 32'h1);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) in_port = 8'($urandom);
      reset      = ($urandom_range(0, 199) == 0);
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) != 0);
      writedata  = $urandom;
      step();
    end
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    steps(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
